// File: rtl/m65c02_ucycle_pkg.sv
// Shared definitions for the M65C02A microcycle controller: state encodings and
// the default microword Len field width.
package m65c02_ucycle_pkg;

  localparam int unsigned LEN_W_DEF = 2;

  localparam logic [1:0] sRST  = 2'd0;
  localparam logic [1:0] sRUN  = 2'd1;
  localparam logic [1:0] sWAIT = 2'd2;
  localparam logic [1:0] sHALT = 2'd3;

endpackage

// File: rtl/m65c02_wait_timer.sv
// Wait-state counter for the terminal phase. It saturates at pWaitMax-1 and
// flags that value as terminal count, which qualifies the timeout.
module m65c02_wait_timer #(
  parameter int unsigned pWaitMax = 16,
  parameter int unsigned pCntW    = $clog2(pWaitMax)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  input  logic Inc,
  output logic Tc
);

  localparam logic [pCntW-1:0] TC_VAL = pCntW'(pWaitMax - 1);

  logic [pCntW-1:0] wait_cnt;

  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      wait_cnt <= '0;
    end else if (Inc && (wait_cnt != TC_VAL)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign Tc = (wait_cnt == TC_VAL);

endmodule

// File: rtl/m65c02_ucycle_ctrl.sv
// Microcycle controller: stretches each MPC microcycle to Len+1 clocks plus
// memory wait states, and produces Rdy on the final clock of each microcycle.
module m65c02_ucycle_ctrl
  import m65c02_ucycle_pkg::*;
#(
  parameter int unsigned pLenW    = LEN_W_DEF,
  parameter int unsigned pWaitMax = 16,
  parameter bit          pWaitEn  = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [pLenW-1:0] Len,
  input  logic             Wait,
  input  logic             ErrClr,
  output logic             Rdy,
  output logic             Start,
  output logic [pLenW-1:0] Phi,
  output logic             Tmo,
  output logic             Err
);

  logic [1:0]       state;
  logic [pLenW-1:0] len_q;
  logic [pLenW-1:0] len_eff;
  logic             wait_eff;
  logic             in_run;
  logic             in_wait;
  logic             at_term;
  logic             wt_tc;
  logic             done;
  logic             tmo_evt;
  logic             wt_inc;

  // Len is only trusted on the Start clock; afterwards the latched copy rules.
  assign len_eff  = Start ? Len : len_q;
  assign wait_eff = Wait & pWaitEn;
  assign in_run   = (state == sRUN);
  assign in_wait  = (state == sWAIT);
  assign at_term  = (Phi == len_eff);

  assign done    = ~Rst & ((in_run & at_term & ~wait_eff) |
                           (in_wait & (~wait_eff | wt_tc)));
  assign tmo_evt = ~Rst & in_wait & wait_eff & wt_tc;
  assign wt_inc  = ~Rst & wait_eff & ((in_run & at_term) | in_wait);
  assign Rdy     = done;

  m65c02_wait_timer #(
    .pWaitMax (pWaitMax)
  ) u_wait_timer (
    .Clk (Clk),
    .Rst (Rst),
    .Clr (done),
    .Inc (wt_inc),
    .Tc  (wt_tc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= sRST;
      Start <= 1'b0;
      Phi   <= '0;
      Tmo   <= 1'b0;
      Err   <= 1'b0;
      len_q <= '0;
    end else begin
      Tmo <= tmo_evt;
      // Tmo is a registered echo of the timeout clock, so a set is honoured on
      // both clocks; ErrClr coincident with either one cannot clear Err.
      Err <= tmo_evt | Tmo | (Err & ~ErrClr);
      if (Start) begin
        len_q <= Len;
      end
      case (state)
        sRST, sHALT: begin
          Phi   <= '0;
          Start <= En;
          state <= En ? sRUN : sHALT;
        end
        default: begin
          if (done) begin
            Phi   <= '0;
            Start <= En;
            state <= En ? sRUN : sHALT;
          end else begin
            Start <= 1'b0;
            if (in_run && at_term) begin
              state <= sWAIT;
            end else if (in_run) begin
              Phi <= Phi + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m65c02_ucycle_ctrl.sv
// Bench for the microcycle controller: directed vectors with literal checks,
// plus a per-clock comparison against a phase/wait-count model of the rules.
module tb_m65c02_ucycle_ctrl;

  localparam int LW   = 2;
  localparam int WMAX = 4;
  localparam bit WEN  = 1'b1;

  logic          Clk    = 1'b0;
  logic          Rst    = 1'b1;
  logic          En     = 1'b1;
  logic          Wait   = 1'b0;
  logic          ErrClr = 1'b0;
  logic [LW-1:0] Len    = '0;
  logic          Rdy;
  logic          Start;
  logic [LW-1:0] Phi;
  logic          Tmo;
  logic          Err;

  int n_cmp = 0;
  int n_bad = 0;

  m65c02_ucycle_ctrl #(
    .pLenW    (LW),
    .pWaitMax (WMAX),
    .pWaitEn  (WEN)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .Len    (Len),
    .Wait   (Wait),
    .ErrClr (ErrClr),
    .Rdy    (Rdy),
    .Start  (Start),
    .Phi    (Phi),
    .Tmo    (Tmo),
    .Err    (Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: idle (reset/halt) or inside a microcycle at phase m_pos, having
  // spent m_wc wait clocks in the terminal phase so far.
  bit m_valid = 1'b0;
  bit m_idle  = 1'b1;
  bit m_start = 1'b0;
  bit m_tmo   = 1'b0;
  bit m_err   = 1'b0;
  int m_pos   = 0;
  int m_len   = 0;
  int m_wc    = 0;

  function automatic int cur_len();
    return m_start ? int'(Len) : m_len;
  endfunction

  function automatic bit exp_rdy();
    if (Rst || m_idle || !m_valid) return 1'b0;
    if (m_pos != cur_len()) return 1'b0;
    if (!(Wait && WEN)) return 1'b1;
    return (m_wc >= WMAX - 1);
  endfunction

  initial forever begin
    @(posedge Clk);
    if (Rst) begin
      m_valid = 1'b1; m_idle = 1'b1; m_start = 1'b0; m_tmo = 1'b0;
      m_err = 1'b0; m_pos = 0; m_len = 0; m_wc = 0;
    end else if (m_valid) begin
      bit r, to;
      int l;
      r  = exp_rdy();
      to = r && Wait && WEN;
      l  = cur_len();
      m_err = to || m_tmo || (m_err && !ErrClr);
      m_tmo = to;
      if (m_idle) begin
        if (En) begin m_idle = 1'b0; m_start = 1'b1; m_pos = 0; m_wc = 0; end
      end else if (r) begin
        m_pos = 0; m_wc = 0;
        if (En) m_start = 1'b1;
        else begin m_start = 1'b0; m_idle = 1'b1; end
      end else begin
        if (m_start) m_len = int'(Len);
        m_start = 1'b0;
        if (m_pos == l) m_wc++;
        else m_pos++;
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (m_valid) begin
      chk("m_rdy",   Rdy,   exp_rdy());
      chk("m_start", Start, m_start);
      chk("m_phi",   Phi,   m_pos);
      chk("m_tmo",   Tmo,   m_tmo);
      chk("m_err",   Err,   m_err);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    step(); step(); step();
    @(negedge Clk); chk("rst_rdy", Rdy, 0); chk("rst_start", Start, 0); chk("rst_phi", Phi, 0);
    step(); Rst = 1'b0;
    @(negedge Clk); chk("rel_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("len0_rdy", Rdy, 1); chk("len0_start", Start, 1);
    step(); @(negedge Clk); chk("len0_rdy2", Rdy, 1); chk("len0_phi", Phi, 0);
    // Len=3 microcycle; Len changes at Phi 1 and 2 must not shorten it
    step(); Len = 2'd3;
    @(negedge Clk); chk("l3_p0_start", Start, 1); chk("l3_p0_rdy", Rdy, 0);
    step(); Len = 2'd0;
    @(negedge Clk); chk("l3_p1_phi", Phi, 1); chk("l3_p1_rdy", Rdy, 0);
    step(); Len = 2'd1;
    @(negedge Clk); chk("l3_p2_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("l3_p3_rdy", Rdy, 1); chk("l3_p3_phi", Phi, 3);
    // Len=1 with three wait clocks, Wait drops on the terminal-count clock
    step(); Wait = 1'b1;
    @(negedge Clk); chk("w_p0_start", Start, 1); chk("w_p0_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("w_t1_rdy", Rdy, 0); chk("w_t1_phi", Phi, 1);
    step(); @(negedge Clk); chk("w_t2_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("w_t3_rdy", Rdy, 0); chk("w_t3_phi", Phi, 1);
    step(); Wait = 1'b0;
    @(negedge Clk); chk("w_t4_rdy", Rdy, 1); chk("w_t4_tmo", Tmo, 0);
    // Len=0 with Wait stuck: timeout on the fourth wait clock
    step(); Len = 2'd0; Wait = 1'b1;
    @(negedge Clk); chk("t_start", Start, 1); chk("t_tmo0", Tmo, 0); chk("t_rdy0", Rdy, 0);
    step(); @(negedge Clk); chk("t_w2_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("t_w3_rdy", Rdy, 0);
    step(); @(negedge Clk); chk("to_rdy", Rdy, 1); chk("to_tmo_early", Tmo, 0);
    step(); @(negedge Clk); chk("to_tmo", Tmo, 1); chk("to_err", Err, 1);
    step(); ErrClr = 1'b1;
    @(negedge Clk); chk("err_sticky", Err, 1); chk("tmo_pulse", Tmo, 0);
    step(); ErrClr = 1'b0;
    @(negedge Clk); chk("err_clr", Err, 0);
    step(); ErrClr = 1'b1;
    @(negedge Clk); chk("to2_rdy", Rdy, 1); chk("to2_err0", Err, 0);
    // ErrClr held across the Tmo pulse; also drop En at Phi 0 of a Len=2 cycle
    step(); Wait = 1'b0; Len = 2'd2; En = 1'b0;
    @(negedge Clk); chk("to2_tmo", Tmo, 1); chk("to2_err", Err, 1); chk("h_p0_rdy", Rdy, 0);
    step(); ErrClr = 1'b0;
    @(negedge Clk); chk("err_setwins", Err, 1); chk("h_p1_phi", Phi, 1);
    step(); @(negedge Clk); chk("h_p2_rdy", Rdy, 1); chk("h_p2_phi", Phi, 2);
    step(); @(negedge Clk); chk("halt_rdy", Rdy, 0); chk("halt_start", Start, 0); chk("halt_phi", Phi, 0);
    step(); En = 1'b1;
    @(negedge Clk); chk("halt2_rdy", Rdy, 0);
    step(); Wait = 1'b1;
    @(negedge Clk); chk("resume_start", Start, 1);
    step(); @(negedge Clk); chk("r_p1_phi", Phi, 1);
    step(); @(negedge Clk); chk("r_p2_rdy", Rdy, 0); chk("r_p2_phi", Phi, 2);
    // Rst while waiting in the terminal phase
    step(); Rst = 1'b1;
    @(negedge Clk); chk("rst_wait_rdy", Rdy, 0); chk("rst_wait_phi", Phi, 2);
    step(); Rst = 1'b0; Wait = 1'b0;
    @(negedge Clk); chk("ab_rdy", Rdy, 0); chk("ab_start", Start, 0); chk("ab_phi", Phi, 0);
    chk("ab_tmo", Tmo, 0); chk("ab_err", Err, 0);
    // Counter must restart from zero: timeout again exactly on the fourth wait clock
    step(); Len = 2'd0; Wait = 1'b1;
    @(negedge Clk); chk("ab2_start", Start, 1); chk("ab2_rdy", Rdy, 0);
    step(); step();
    @(negedge Clk); chk("ab2_w3_rdy", Rdy, 0);
    step(); En = 1'b0;
    @(negedge Clk); chk("to3_rdy", Rdy, 1);
    step(); @(negedge Clk); chk("to3_tmo", Tmo, 1); chk("to3_start", Start, 0); chk("to3_rdy0", Rdy, 0);
    // Longer directed pattern, checked by the model every clock
    Wait = 1'b0; En = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      En     = (i % 37) < 30;
      Wait   = ((i % 23) >= 15) || (((i * 5) % 13) == 0);
      Len    = LW'((i / 7) % 4);
      ErrClr = (i % 29) == 3;
      Rst    = (i % 97) == 50;
    end
    step(); Rst = 1'b0;
    step();
    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
